// File: rtl/roberto_tx_serial.sv
// rtl/roberto_tx_serial.sv - ASCII byte formatter and 8N1 UART transmitter for the Roberto report flow
module roberto_tx_serial #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        partida,
    input  logic [11:0] medida0,
    input  logic [11:0] medida1,
    input  logic [11:0] medida2,
    input  logic [1:0]  sel_sensor,
    input  logic [1:0]  sel_byte,
    output logic        saida_serial,
    output logic        pronto,
    output logic [7:0]  db_byte,
    output logic [3:0]  db_estado
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_FINAL = 3'd5
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [7:0]      byte_q;
    logic            saida_q;
    logic            pronto_q;

    logic [11:0]     medida_sel;
    logic [3:0]      digit;
    logic [7:0]      byte_d;
    logic            baud_end;

    // Selected measurement and its ASCII rendering; only consumed in LOAD.
    always_comb begin
        medida_sel = 12'h000;
        case (sel_sensor)
            2'd0:    medida_sel = medida0;
            2'd1:    medida_sel = medida1;
            2'd2:    medida_sel = medida2;
            default: medida_sel = 12'h000;
        endcase
        digit = 4'h0;
        case (sel_byte)
            2'd0:    digit = medida_sel[11:8];
            2'd1:    digit = medida_sel[7:4];
            default: digit = medida_sel[3:0];
        endcase
        byte_d = 8'h30 + {4'h0, digit};
        if (sel_byte == 2'd3) begin
            byte_d = 8'h23;
        end else if (sel_sensor == 2'd3 || digit > 4'd9) begin
            byte_d = 8'h3F;
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            byte_q   <= 8'h00;
            saida_q  <= 1'b1;
            pronto_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    saida_q  <= 1'b1;
                    pronto_q <= 1'b0;
                    if (partida) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q <= byte_d;
                    byte_q  <= byte_d;
                    baud_q  <= '0;
                    bit_q   <= 3'd0;
                    saida_q <= 1'b0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        saida_q <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            saida_q <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            // Line is registered, so present the next bit as the shift advances.
                            bit_q   <= bit_q + 3'd1;
                            saida_q <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_q   <= '0;
                        pronto_q <= 1'b1;
                        state_q  <= S_FINAL;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_FINAL: begin
                    pronto_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    saida_q  <= 1'b1;
                    pronto_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        db_estado = 4'hF;
        case (state_q)
            S_IDLE:  db_estado = 4'h0;
            S_LOAD:  db_estado = 4'h1;
            S_START: db_estado = 4'h2;
            S_DATA:  db_estado = 4'h3;
            S_STOP:  db_estado = 4'h4;
            S_FINAL: db_estado = 4'h5;
            default: db_estado = 4'hF;
        endcase
    end

    assign saida_serial = saida_q;
    assign pronto       = pronto_q;
    assign db_byte      = byte_q;

endmodule

// File: tb/tb_roberto_tx_serial.sv
// tb/tb_roberto_tx_serial.sv - randomized scoreboard bench for roberto_tx_serial
module tb_roberto_tx_serial;

    localparam int BD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        partida;
    logic [11:0] medida0, medida1, medida2;
    logic [1:0]  sel_sensor, sel_byte;
    logic        saida_serial, pronto;
    logic [7:0]  db_byte;
    logic [3:0]  db_estado;

    int tests = 0;
    int fails = 0;
    int frames_sent = 0;
    int frames_done = 0;
    int pronto_cnt = 0;
    logic [7:0] exp_q[$];

    roberto_tx_serial #(.BAUD_DIV(BD)) dut (
        .clock(clock), .reset(reset), .partida(partida),
        .medida0(medida0), .medida1(medida1), .medida2(medida2),
        .sel_sensor(sel_sensor), .sel_byte(sel_byte),
        .saida_serial(saida_serial), .pronto(pronto),
        .db_byte(db_byte), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ASCII report character from the BCD measurement rules.
    function automatic logic [7:0] ref_byte(input int m0, input int m1, input int m2,
                                            input int s, input int b);
        int m;
        int d;
        if (b == 3) return 8'h23;
        if (s == 3) return 8'h3F;
        m = (s == 0) ? m0 : (s == 1) ? m1 : m2;
        d = (m / (1 << (4 * (2 - b)))) % 16;
        if (d > 9) return 8'h3F;
        return 8'(48 + d);
    endfunction

    // Issue one request like the control unit: hold partida until pronto, drop for one cycle.
    task automatic send(input int s, input int b, input bit mutate);
        int n;
        exp_q.push_back(ref_byte(medida0, medida1, medida2, s, b));
        frames_sent++;
        sel_sensor = s[1:0];
        sel_byte   = b[1:0];
        partida    = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (mutate && n == 3) begin
                medida0  = ~medida0;
                sel_byte = sel_byte + 2'd1;
            end
            if (pronto) break;
        end
        chk("latency_from_request", n, 2 + 10 * BD + 1);
        @(posedge clock); #1 partida = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin : monitor
        logic       prev;
        logic [7:0] e;
        logic [9:0] fr;
        int         bad, early;
        bit         ab;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset && prev === 1'b1 && saida_serial === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    e = 8'h00;
                end else begin
                    e = exp_q.pop_front();
                end
                chk("db_byte_at_start", int'(db_byte), int'(e));
                fr = {1'b1, e, 1'b0};
                bad = 0; early = 0; ab = 1'b0;
                for (int c = 0; c < 10 * BD; c++) begin
                    if (c > 0) @(negedge clock);
                    if (reset) begin
                        ab = 1'b1;
                        break;
                    end
                    if (saida_serial !== fr[c / BD]) bad++;
                    if (pronto !== 1'b0) early++;
                end
                if (!ab) begin
                    chk("frame_line_bits", bad, 0);
                    chk("pronto_before_stop_end", early, 0);
                    @(negedge clock);
                    chk("pronto_on_time", int'(pronto), 1);
                    frames_done++;
                end
            end
            prev = saida_serial;
        end
    end

    initial begin : pronto_counter
        forever begin
            @(negedge clock);
            if (pronto === 1'b1) pronto_cnt++;
        end
    end

    initial begin
        int n;
        reset = 1'b1; partida = 1'b0;
        medida0 = 12'h000; medida1 = 12'h000; medida2 = 12'h000;
        sel_sensor = 2'd0; sel_byte = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_line", int'(saida_serial), 1);
        chk("reset_pronto", int'(pronto), 0);
        chk("reset_db_byte", int'(db_byte), 0);
        chk("reset_state", int'(db_estado), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        medida0 = 12'h123;
        send(0, 0, 1'b0);
        chk("hundreds_s0", int'(db_byte), 8'h31);

        medida2 = 12'h407;
        send(2, 1, 1'b0); chk("tens_s2", int'(db_byte), 8'h30);
        send(2, 2, 1'b0); chk("units_s2", int'(db_byte), 8'h37);
        send(2, 3, 1'b0); chk("sep_s2", int'(db_byte), 8'h23);

        medida1 = 12'h1A5;
        send(1, 1, 1'b0); chk("bad_digit", int'(db_byte), 8'h3F);
        send(3, 0, 1'b0); chk("bad_sensor", int'(db_byte), 8'h3F);
        send(3, 3, 1'b0); chk("sep_sensor3", int'(db_byte), 8'h23);

        medida0 = 12'($urandom); medida1 = 12'($urandom); medida2 = 12'($urandom);
        for (int s = 0; s < 3; s++)
            for (int b = 0; b < 4; b++)
                send(s, b, 1'b0);

        // Abort in DATA bit 3, then resend.
        medida0 = 12'h456;
        exp_q.push_back(ref_byte(medida0, medida1, medida2, 0, 2));
        frames_sent++;
        sel_sensor = 2'd0; sel_byte = 2'd2; partida = 1'b1;
        n = 0;
        while (n < 100 && db_estado !== 4'h3) begin
            @(negedge clock);
            n++;
        end
        chk("reached_data", int'(db_estado), 3);
        repeat (12) @(posedge clock);
        #1 reset = 1'b1; partida = 1'b0;
        @(posedge clock); #1;
        chk("abort_line", int'(saida_serial), 1);
        chk("abort_state", int'(db_estado), 0);
        chk("abort_pronto", int'(pronto), 0);
        reset = 1'b0;
        repeat (10 * BD) @(posedge clock);
        #1;
        send(0, 2, 1'b0);
        chk("resend_byte", int'(db_byte), 8'h36);

        medida0 = 12'h789;
        send(0, 1, 1'b1);
        chk("latched_in_load", int'(db_byte), 8'h38);

        for (int i = 0; i < 20; i++) begin
            medida0 = 12'($urandom); medida1 = 12'($urandom); medida2 = 12'($urandom);
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clock);
        #1;
        chk("frames_completed", frames_done, frames_sent - 1);
        chk("pronto_pulses", pronto_cnt, frames_sent - 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/roberto_tx_serial.md
Name: roberto_tx_serial

Overview:
- Serial transmit stage for the Roberto measurement-and-report flow.
- Sits directly downstream of the game control unit. The control unit holds partida high while in its send state and selects the sensor index and byte index.
- The block formats one ASCII byte from the latched BCD distance measurements, transmits it as an 8N1 UART frame and returns a one-cycle pronto pulse.
- A report is 3 sensors x 4 bytes: hundreds, tens, units, separator.

Parameters:
- BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200). Legal range 2..4095.

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- partida  in  1  level request to transmit; sampled only in IDLE
- medida0  in  12  sensor 0 distance, 3 BCD digits [11:8]=hundreds [7:4]=tens [3:0]=units
- medida1  in  12  sensor 1 distance, same format
- medida2  in  12  sensor 2 distance, same format
- sel_sensor  in  2  sensor index 0..2 (the control unit's sensor counter)
- sel_byte  in  2  byte index 0..3 (the control unit's byte counter)
- saida_serial  out  1  UART TX line, idle high
- pronto  out  1  one-cycle pulse when the stop bit has completed
- db_byte  out  8  byte latched for the current or last frame
- db_estado  out  4  current state code

Behaviour:
- Reset, synchronous, takes effect at the next clock edge:
  - state goes to IDLE; saida_serial=1; pronto=0; db_byte=0x00; bit and baud counters cleared.
  - Reset asserted mid-frame aborts the frame: line high the next cycle, no pronto.
- States and db_estado codes: IDLE 0000, LOAD 0001, START 0010, DATA 0011, STOP 0100, FINAL 0101. Any illegal code reports 1111 and goes to IDLE.
- IDLE: line high. partida=1 at an edge moves to LOAD; otherwise stay.
- LOAD (1 cycle): latch the formatted byte into the shift register and db_byte. The byte is selected from sel_sensor/sel_byte as sampled in this cycle:
  - sel_byte 0/1/2 -> 0x30 + hundreds/tens/units digit of the selected medida.
  - sel_byte 3 -> 0x23 ('#').
  - Digit >9, or sel_sensor=3 with sel_byte<3 -> 0x3F ('?').
- START: line 0 for exactly BAUD_DIV cycles.
- DATA: 8 bits sent LSB first, each held BAUD_DIV cycles. The bit counter runs 0..7; leave DATA after bit 7's last cycle.
- STOP: line 1 for BAUD_DIV cycles, then go to FINAL.
- FINAL (1 cycle): pronto=1 and partida is ignored; then go to IDLE.
- Latency: pronto asserts 10*BAUD_DIV cycles after the first START cycle, and 10*BAUD_DIV+1 cycles after LOAD.
- Outputs: saida_serial and pronto are registered (glitch-free). pronto is high in no state other than FINAL.
- Input changes after LOAD (partida, sel_*, medida*) do not affect the frame in flight.
- Handshake with the control unit:
  - The control unit leaves its send state on pronto. The one-cycle FINAL guarantees the partida level left over from that send state never starts a second frame.
  - The next frame starts only when partida is high in IDLE. Back-to-back requests therefore cost 2 cycles of IDLE gap minimum.
- partida held continuously high: transmits repeatedly, one frame per FINAL->IDLE->LOAD cycle.
- Baud counter: width ceil(log2(BAUD_DIV)); wraps to 0 at BAUD_DIV-1 on each bit boundary.

Test Plan:
- BAUD_DIV=4, medida0=12'h123, sel_sensor=0, sel_byte=0, partida pulse -> db_byte=0x31. Line low 4 cycles, then bits 1,0,0,0,1,1,0,0 (4 cycles each), then high 4 cycles. pronto single pulse 41 cycles after LOAD.
- medida2=12'h407, sel_sensor=2, sel_byte=1/2/3 in successive frames -> bytes 0x30, 0x37, 0x23, each followed by exactly one pronto.
- medida1=12'h1A5, sel_sensor=1, sel_byte=1 -> 0x3F. sel_sensor=3, sel_byte=0 -> 0x3F. sel_sensor=3, sel_byte=3 -> 0x23.
- Drive partida like the control unit (high until pronto, low 1 cycle, high again) for 12 bytes -> exactly 12 frames and 12 pronto pulses, no extra frame.
- Assert reset in DATA bit 3 -> next cycle saida_serial=1, db_estado=0000, pronto stays 0. A new partida then sends a complete, correct frame.
- Change medida0 and sel_byte during START -> transmitted byte equals the value latched in LOAD.
